mux_nway_rr: RTL and testbench

Parametrised N-way, W-bit registered multiplexer with per-channel valid/ready handshake and selectable fixed-select or round-robin arbitration. It replaces hard-sized combinational selectors wherever several producers share one consumer. Examples: register-file read ports, memory-mapped peripheral return paths, I/O muxing in the CPU datapath. One output register stage gives a one-cycle latency at full throughput.

---
 rtl/mux_nway_pkg.sv | 12 +
 rtl/mux_nway_rr_if.sv | 43 ++++
 rtl/mux_nway_rr_arbiter.sv | 51 +++++
 rtl/mux_nway_rr.sv | 110 +++++++++++
 tb/tb_mux_nway_rr.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mux_nway_pkg.sv
// mux_nway_pkg: constants shared by the N-way registered multiplexer.
//   MODE_FIXED / MODE_RR : values of the 1-bit `mode` input
//   DEFAULT_N / DEFAULT_W : default channel count and data width
`ifndef MUX_NWAY_PKG_SV
`define MUX_NWAY_PKG_SV
package mux_nway_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   DEFAULT_N  = 8;
    localparam int   DEFAULT_W  = 16;
endpackage
`endif

// File: rtl/mux_nway_rr_if.sv
// mux_nway_rr_if: bundles the N input channels, the selection controls and
// the single output channel of mux_nway_rr.
//   in_data/in_valid/in_ready : N producer channels, channel i at [i*W +: W]
//   mode/sel                  : arbitration mode and fixed-mode channel index
//   out_data/out_chan/out_valid/out_ready : registered consumer channel
//   out_parity                : present only with MUX_NWAY_PARITY_EN
// slave modport = the multiplexer, master modport = its environment.
interface mux_nway_rr_if
    import mux_nway_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int W    = DEFAULT_W,
    parameter int SELW = $clog2(N)
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;
`ifdef MUX_NWAY_PARITY_EN
    logic            out_parity;
`endif

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
`ifdef MUX_NWAY_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
`ifdef MUX_NWAY_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/mux_nway_rr_arbiter.sv
// rr_arbiter: purely combinational grant selection for mux_nway_rr.
//   req_i         : per-channel request (in_valid)
//   ptr_i         : last round-robin winner; scan starts at ptr_i+1
//   mode_i        : MODE_FIXED or MODE_RR
//   sel_i         : channel index used in fixed mode
//   grant_valid_o : a channel is granted
//   grant_idx_o   : index of the granted channel (0 when none)
module rr_arbiter
    import mux_nway_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            mode_i,
    input  logic [SELW-1:0] sel_i,
    output logic            grant_valid_o,
    output logic [SELW-1:0] grant_idx_o
);
    // sel can encode indices up to 2**SELW-1; widen the request vector so a
    // dynamic select never runs past its end when N is not a power of two.
    localparam int NP = 1 << SELW;

    logic [NP-1:0] req_ext;
    int            idx;

    assign req_ext = NP'(req_i);

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        if (mode_i == MODE_FIXED) begin
            if (int'(sel_i) < N) begin
                grant_valid_o = req_ext[sel_i];
                grant_idx_o   = sel_i;
            end
        end else begin
            // Scan from the farthest to the nearest position after ptr; the
            // last hit is the nearest, which is the round-robin winner.
            for (int k = N; k >= 1; k--) begin
                idx = (int'(ptr_i) + k) % N;
                if (req_i[idx]) begin
                    grant_valid_o = 1'b1;
                    grant_idx_o   = SELW'(idx);
                end
            end
        end
    end
endmodule

// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-way, W-bit registered multiplexer with valid/ready
// handshake and fixed-select or round-robin arbitration. One output register
// gives one cycle of latency at full throughput.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_nway_rr_if.slave (inputs, controls, output channel)
// Optional feature: define MUX_NWAY_PARITY_EN to add a registered even-parity
// bit (out_parity) alongside out_data.
module mux_nway_rr
    import mux_nway_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int W    = DEFAULT_W,
    parameter int SELW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_nway_rr_if.slave bus
);
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_chan_q, out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;
`ifdef MUX_NWAY_PARITY_EN
    logic            out_parity_q, out_parity_d;
`endif

    logic            load;
    logic            xfer;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [W-1:0]    grant_data;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req_i         (bus.in_valid),
        .ptr_i         (ptr_q),
        .mode_i        (bus.mode),
        .sel_i         (bus.sel),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign load       = !out_valid_q || bus.out_ready;
    assign xfer       = load && grant_valid;
    assign grant_data = bus.in_data[grant_idx*W +: W];

    // Ready is held low during reset so no producer believes a word was
    // taken on an edge where the register is being cleared.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && xfer) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_valid_d  = out_valid_q;
        ptr_d        = ptr_q;
`ifdef MUX_NWAY_PARITY_EN
        out_parity_d = out_parity_q;
`endif
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
`ifdef MUX_NWAY_PARITY_EN
            out_parity_d = ^grant_data;
`endif
            // Fixed-mode traffic must not disturb round-robin fairness.
            if (bus.mode == MODE_RR) begin
                ptr_d = grant_idx;
            end
        end else if (load) begin
            // Data and channel hold; only the valid flag drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_valid_q  <= 1'b0;
            ptr_q        <= SELW'(N - 1);   // channel 0 wins first
`ifdef MUX_NWAY_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_valid_q  <= out_valid_d;
            ptr_q        <= ptr_d;
`ifdef MUX_NWAY_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_chan   = out_chan_q;
    assign bus.out_valid  = out_valid_q;
`ifdef MUX_NWAY_PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_mux_nway_rr.sv
module tb_mux_nway_rr;
    localparam int N    = 8;
    localparam int W    = 16;
    localparam int SELW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nway_rr_if #(.N(N), .W(W), .SELW(SELW)) bus ();
    mux_nway_rr #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Second instance with a non-power-of-two channel count.
    mux_nway_rr_if #(.N(10), .W(W), .SELW(4)) bus10 ();
    mux_nway_rr #(.N(10), .W(W), .SELW(4)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    int total = 0;
    int bad   = 0;

    // Reference state of the output register and rotation pointer.
    bit          m_valid;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;
    bit          m_par;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel that should win, or -1: fixed = sel if in range and valid;
    // round-robin = first valid channel after the last winner, cyclically.
    function automatic int pick(input logic [N-1:0] v, input bit md, input int s, input int p);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_par = 0;
    endtask

    // Called at a falling edge with the inputs already driven: checks the
    // combinational ready and the registered outputs, then advances the
    // model and the clock by one cycle.
    task automatic step();
        int          g;
        bit          ld;
        logic [N-1:0] exp_rdy;
        logic [15:0]  w;
        #1;
        ld = !m_valid || bus.out_ready;
        g  = rst_n ? pick(bus.in_valid, bus.mode, int'(bus.sel), m_ptr) : -1;
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("out_data", 64'(bus.out_data), 64'(m_data));
        check("out_chan", 64'(bus.out_chan), 64'(m_chan));
`ifdef MUX_NWAY_PARITY_EN
        check("out_parity", 64'(bus.out_parity), 64'(m_par));
`endif
        if (!rst_n) begin
            model_reset();
        end else if (ld && g >= 0) begin
            w = bus.in_data[g*W +: W];
            m_data = w; m_chan = g; m_valid = 1; m_par = ^w;
            if (bus.mode) m_ptr = g;
        end else if (ld) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_inc();
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'h1000 + 16'(i);
    endtask

    initial begin
        logic [15:0] held;
        rst_n = 1'b0;
        bus.in_data = '0; bus.in_valid = '0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b0;
        bus10.in_data = '0; bus10.in_valid = '0; bus10.mode = 1'b0; bus10.sel = '0; bus10.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();                                   // reset state, in_ready low

        // Fixed mode, sel=3
        rst_n = 1'b1;
        bus.mode = 1'b0; bus.sel = 3'd3; bus.in_valid = 8'h08; bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'($urandom);
        bus.in_data[3*W +: W] = 16'hBEEF;
        #1 check("tp1_ready", 64'(bus.in_ready), 64'h08);
        step();
        bus.in_valid = '0;
        check("tp1_data", 64'(bus.out_data), 64'hBEEF);
        check("tp1_chan", 64'(bus.out_chan), 64'd3);
        check("tp1_valid", 64'(bus.out_valid), 64'd1);
        step();

        // Round-robin, all channels valid, no bubbles
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.mode = 1'b1; bus.in_valid = 8'hFF; fill_inc();
        for (int i = 0; i < 9; i++) begin
            step();
            check("rr_seq_chan", 64'(bus.out_chan), 64'(i % N));
            check("rr_seq_data", 64'(bus.out_data), 64'(16'h1000 + 16'(i % N)));
            check("rr_seq_valid", 64'(bus.out_valid), 64'd1);
        end

        // Wrap-around with channels 0 and 7
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.in_valid = 8'h81;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_wrap_chan", 64'(bus.out_chan), (i % 2 == 0) ? 64'd0 : 64'd7);
        end

        // Backpressure: three stalled cycles, then drain and load same edge
        bus.in_valid = 8'hFF; bus.out_ready = 1'b0;
        held = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 64'(bus.in_ready), 64'd0);
            step();
            check("bp_hold", 64'(bus.out_data), 64'(held));
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_reload_valid", 64'(bus.out_valid), 64'd1);
        check("bp_reload_chan", 64'(bus.out_chan), 64'd0);

        // Reset while holding a word
        bus.out_ready = 1'b0;
        rst_n = 1'b0; step();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_chan", 64'(bus.out_chan), 64'd0);
        rst_n = 1'b1; bus.out_ready = 1'b1; bus.mode = 1'b1; bus.in_valid = 8'hFF;
        step();
        check("rst_first_grant", 64'(bus.out_chan), 64'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rst_n         = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.in_valid  = 8'($urandom);
            bus.mode      = 1'($urandom);
            bus.sel       = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'($urandom);
            step();
        end
        rst_n = 1'b1; bus.in_valid = '0; bus.out_ready = 1'b1;
        step();
        step();

        // N=10: in-range high index grants, out-of-range index never does
        bus10.mode = 1'b0; bus10.sel = 4'd9; bus10.in_valid = 10'h200; bus10.out_ready = 1'b1;
        bus10.in_data[9*W +: W] = 16'hA55A;
        #1 check("n10_ready9", 64'(bus10.in_ready), 64'h200);
        @(posedge clk); @(negedge clk);
        check("n10_valid9", 64'(bus10.out_valid), 64'd1);
        check("n10_chan9", 64'(bus10.out_chan), 64'd9);
        check("n10_data9", 64'(bus10.out_data), 64'hA55A);
        bus10.sel = 4'd12; bus10.in_valid = 10'h3FF;
        #1 check("n10_ready_oor", 64'(bus10.in_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        check("n10_valid_oor", 64'(bus10.out_valid), 64'd0);
        check("n10_chan_hold", 64'(bus10.out_chan), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
